// File: rtl/prime_search_ctrl_if.sv
// ---------------------------------------------------------------------------
// prime_search_ctrl_if
//   Bundles the request side (start/abort/seed/accuracy in, status out) and
//   the tester side (mr_*) of the prime search controller.
//
//   Modports:
//     slave  : the controller's view (drives status and tester controls)
//     master : the requester / tester-owner view
//
//   Signals:
//     start, abort, seed_number, accuracy      request inputs to controller
//     busy, done, found, overflow              search status
//     prime_out, tries                         search result
//     mr_start_number, mr_accuracy, mr_reset   tester controls
//     mr_prime, mr_finish                      tester verdict
// ---------------------------------------------------------------------------
interface prime_search_ctrl_if #(
    parameter int WORDSIZE = 32
);
    logic                start;
    logic                abort;
    logic [WORDSIZE-1:0] seed_number;
    logic [WORDSIZE-1:0] accuracy;
    logic                busy;
    logic                done;
    logic                found;
    logic                overflow;
    logic [WORDSIZE-1:0] prime_out;
    logic [15:0]         tries;
    logic [WORDSIZE-1:0] mr_start_number;
    logic [WORDSIZE-1:0] mr_accuracy;
    logic                mr_reset;
    logic                mr_prime;
    logic                mr_finish;

    modport slave (
        input  start, abort, seed_number, accuracy, mr_prime, mr_finish,
        output busy, done, found, overflow, prime_out, tries,
               mr_start_number, mr_accuracy, mr_reset
    );

    modport master (
        output start, abort, seed_number, accuracy, mr_prime, mr_finish,
        input  busy, done, found, overflow, prime_out, tries,
               mr_start_number, mr_accuracy, mr_reset
    );
endinterface

// File: rtl/prime_search_ctrl.sv
// ---------------------------------------------------------------------------
// prime_search_ctrl
//   Sequencing controller for one miller_rabin tester. Walks odd candidates
//   upward from a seed, runs the tester on each, and stops on the first
//   probable prime, on MAX_TRIES candidates, on word overflow, or on abort.
//
//   Parameters:
//     WORDSIZE  : candidate / accuracy width (must match the tester)
//     MAX_TRIES : maximum candidates examined per search (1..65535)
//
//   Ports:
//     clk   : clock
//     reset : asynchronous active-high reset
//     bus   : prime_search_ctrl_if.slave (request, status and tester signals)
//
//   Optional build macro:
//     PRIME_SEARCH_SIEVE_EN : keep candidate residues mod 3/5/7 and reject
//                             small-factor candidates without the tester.
// ---------------------------------------------------------------------------
module prime_search_ctrl #(
    parameter int WORDSIZE  = 32,
    parameter int MAX_TRIES = 1024
) (
    input logic                clk,
    input logic                reset,
    prime_search_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef PRIME_SEARCH_SIEVE_EN
        S_SIEVE,
`else
        S_ISSUE,
`endif
        S_GUARD,
        S_WAIT,
        S_EVAL,
        S_FINISH
    } state_t;

    // State that launches a candidate (ISSUE, or SIEVE when residues exist)
`ifdef PRIME_SEARCH_SIEVE_EN
    localparam state_t S_TEST = S_SIEVE;
`else
    localparam state_t S_TEST = S_ISSUE;
`endif

    localparam logic [15:0]         MAX_TRIES16 = 16'(MAX_TRIES);
    // Largest candidate that can still take a +2 step without wrapping
    localparam logic [WORDSIZE-1:0] CAND_LIMIT  = {WORDSIZE{1'b1}} - WORDSIZE'(2);

    state_t              state;
    logic [WORDSIZE-1:0] candidate;
    logic [WORDSIZE-1:0] acc_q;
    logic                prime_q;

    logic [WORDSIZE-1:0] cand_init;
    logic                start_ok;
    logic                tries_hit;
    logic                cand_top;
    logic                eval_step;
    logic                sieve_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign cand_init = bus.seed_number | WORDSIZE'(1);
    assign start_ok  = bus.start && !bus.abort;
    assign tries_hit = (bus.tries == MAX_TRIES16);
    assign cand_top  = (candidate > CAND_LIMIT);
    assign eval_step = !prime_q && !tries_hit && !cand_top;

`ifdef PRIME_SEARCH_SIEVE_EN
    logic [2:0] r3, r5, r7;

    // Residue advance by +2 with wrap; avoids any divider in the loop
    function automatic logic [2:0] mod_add2(input logic [2:0] r, input logic [2:0] m);
        logic [3:0] s;
        s = {1'b0, r} + 4'd2;
        return (s >= {1'b0, m}) ? 3'(s - {1'b0, m}) : 3'(s);
    endfunction

    // Small primes themselves must still reach the tester
    assign sieve_hit = ((r3 == 3'd0) || (r5 == 3'd0) || (r7 == 3'd0)) &&
                       (candidate > WORDSIZE'(7));
`else
    assign sieve_hit = 1'b0;
`endif

    // Datapath registers: no reset needed, always written before use
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start_ok) begin
            candidate <= cand_init;
            acc_q     <= bus.accuracy;
`ifdef PRIME_SEARCH_SIEVE_EN
            r3 <= 3'(cand_init % WORDSIZE'(3));
            r5 <= 3'(cand_init % WORDSIZE'(5));
            r7 <= 3'(cand_init % WORDSIZE'(7));
`endif
        end else if (state == S_EVAL && eval_step) begin
            candidate <= candidate + WORDSIZE'(2);
`ifdef PRIME_SEARCH_SIEVE_EN
            r3 <= mod_add2(r3, 3'd3);
            r5 <= mod_add2(r5, 3'd5);
            r7 <= mod_add2(r7, 3'd7);
`endif
        end

        // Verdict for EVAL: a sieved candidate counts as composite
        if (state == S_TEST && sieve_hit)
            prime_q <= 1'b0;
        else if (state == S_WAIT && bus.mr_finish)
            prime_q <= bus.mr_prime;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= S_IDLE;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.found           <= 1'b0;
            bus.overflow        <= 1'b0;
            bus.prime_out       <= '0;
            bus.tries           <= '0;
            bus.mr_reset        <= 1'b1;
            bus.mr_start_number <= '0;
            bus.mr_accuracy     <= '0;
        end else begin
            bus.done <= 1'b0;
            if (bus.abort && state != S_IDLE) begin
                // Cancel: results stay as they are, no done pulse
                state        <= S_IDLE;
                bus.busy     <= 1'b0;
                bus.mr_reset <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        bus.mr_reset <= 1'b1;
                        if (start_ok) begin
                            bus.busy     <= 1'b1;
                            bus.found    <= 1'b0;
                            bus.overflow <= 1'b0;
                            bus.tries    <= '0;
                            if (bus.seed_number <= WORDSIZE'(2)) begin
                                bus.prime_out <= WORDSIZE'(2);
                                bus.found     <= 1'b1;
                                state         <= S_FINISH;
                            end else if (bus.seed_number == WORDSIZE'(3)) begin
                                bus.prime_out <= WORDSIZE'(3);
                                bus.found     <= 1'b1;
                                state         <= S_FINISH;
                            end else begin
                                state <= S_TEST;
                            end
                        end
                    end
                    S_TEST: begin
                        bus.tries     <= sat_inc(bus.tries);
                        bus.prime_out <= candidate;
                        if (sieve_hit) begin
                            state <= S_EVAL;
                        end else begin
                            bus.mr_start_number <= candidate;
                            bus.mr_accuracy     <= acc_q;
                            bus.mr_reset        <= 1'b1;
                            state               <= S_GUARD;
                        end
                    end
                    S_GUARD: begin
                        // mr_finish may still be left over from the previous
                        // candidate here, so it is not looked at until WAIT
                        bus.mr_reset <= 1'b0;
                        state        <= S_WAIT;
                    end
                    S_WAIT: begin
                        bus.mr_reset <= 1'b0;
                        if (bus.mr_finish)
                            state <= S_EVAL;
                    end
                    S_EVAL: begin
                        if (prime_q) begin
                            bus.found <= 1'b1;
                            state     <= S_FINISH;
                        end else if (tries_hit) begin
                            state <= S_FINISH;
                        end else if (cand_top) begin
                            bus.overflow <= 1'b1;
                            state        <= S_FINISH;
                        end else begin
                            state <= S_TEST;
                        end
                    end
                    S_FINISH: begin
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        bus.mr_reset <= 1'b1;
                        state        <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prime_search_ctrl.sv
module tb_prime_search_ctrl;

    logic clk;
    logic rst;

    prime_search_ctrl_if #(.WORDSIZE(32)) b0();
    prime_search_ctrl_if #(.WORDSIZE(32)) b1();

    prime_search_ctrl #(.WORDSIZE(32), .MAX_TRIES(1024)) dut0 (
        .clk(clk), .reset(rst), .bus(b0)
    );
    prime_search_ctrl #(.WORDSIZE(32), .MAX_TRIES(2)) dut1 (
        .clk(clk), .reset(rst), .bus(b1)
    );

`ifdef PRIME_SEARCH_SIEVE_EN
    localparam bit SIEVE = 1'b1;
`else
    localparam bit SIEVE = 1'b0;
`endif

    typedef struct {
        bit              found;
        bit              overflow;
        longint unsigned prime;
        int              tries;
        int              runs;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   passes = 0;
    int   runs0 = 0, runs1 = 0;
    logic [31:0] cur_acc0 = 0, cur_acc1 = 0;
    int   lat0 = 0, lat1 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_prime(longint unsigned n);
        if (n < 2) return 1'b0;
        if (n < 4) return 1'b1;
        if (n % 2 == 0) return 1'b0;
        for (longint unsigned d = 3; d * d <= n; d += 2)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: walk odd numbers from seed|1 under the search rules
    function automatic exp_t model(longint unsigned seed, int max_tries);
        exp_t e;
        longint unsigned c;
        int t, n;
        bit rej;
        e.found = 0; e.overflow = 0; e.tries = 0; e.runs = 0;
        if (seed <= 3) begin
            e.found = 1;
            e.prime = (seed == 3) ? 3 : 2;
            return e;
        end
        c = seed | 1;
        t = 0;
        n = 0;
        while (1'b1) begin
            t++;
            rej = SIEVE && (c > 7) && (c % 3 == 0 || c % 5 == 0 || c % 7 == 0);
            if (!rej) n++;
            e.prime = c; e.tries = t; e.runs = n;
            if (!rej && is_prime(c)) begin e.found = 1; return e; end
            if (t == max_tries) return e;
            if (c == 64'hFFFF_FFFF) begin e.overflow = 1; return e; end
            c += 2;
        end
        return e;
    endfunction

    task automatic check(string name, longint unsigned act, longint unsigned req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic fail_evt(string name);
        checks++;
        $display("FAIL %s: event not as required", name);
    endtask

    // Behavioural tester models: finish after a random delay with a true verdict
    always @(posedge clk) begin
        if (b0.mr_reset) begin
            b0.mr_finish <= 1'b0;
            b0.mr_prime  <= 1'($urandom);
            lat0         <= $urandom_range(0, 5);
        end else if (!b0.mr_finish) begin
            if (lat0 == 0) begin
                b0.mr_finish <= 1'b1;
                b0.mr_prime  <= is_prime(64'(b0.mr_start_number));
            end else lat0 <= lat0 - 1;
        end
    end

    always @(posedge clk) begin
        if (b1.mr_reset) begin
            b1.mr_finish <= 1'b0;
            b1.mr_prime  <= 1'($urandom);
            lat1         <= $urandom_range(0, 5);
        end else if (!b1.mr_finish) begin
            if (lat1 == 0) begin
                b1.mr_finish <= 1'b1;
                b1.mr_prime  <= is_prime(64'(b1.mr_start_number));
            end else lat1 <= lat1 - 1;
        end
    end

    // Tester launch counters, with accuracy check on each launch
    initial begin : launch_mon
        logic p0, p1;
        p0 = 1'b1; p1 = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && p0 && !b0.mr_reset) begin
                runs0++;
                check("dut0 mr_accuracy", 64'(b0.mr_accuracy), 64'(cur_acc0));
            end
            if (!rst && p1 && !b1.mr_reset) begin
                runs1++;
                check("dut1 mr_accuracy", 64'(b1.mr_accuracy), 64'(cur_acc1));
            end
            p0 = b0.mr_reset;
            p1 = b1.mr_reset;
        end
    end

    // Scoreboard monitors
    initial begin : mon0
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && b0.done) begin
                if (q0.size() == 0) fail_evt("dut0 unexpected done");
                else begin
                    e = q0.pop_front();
                    check("dut0 found",     64'(b0.found),     64'(e.found));
                    check("dut0 overflow",  64'(b0.overflow),  64'(e.overflow));
                    check("dut0 prime_out", 64'(b0.prime_out), e.prime);
                    check("dut0 tries",     64'(b0.tries),     64'(e.tries));
                    check("dut0 runs",      64'(runs0),        64'(e.runs));
                    check("dut0 busy@done", 64'(b0.busy),      64'(0));
                end
            end
        end
    end

    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && b1.done) begin
                if (q1.size() == 0) fail_evt("dut1 unexpected done");
                else begin
                    e = q1.pop_front();
                    check("dut1 found",     64'(b1.found),     64'(e.found));
                    check("dut1 overflow",  64'(b1.overflow),  64'(e.overflow));
                    check("dut1 prime_out", 64'(b1.prime_out), e.prime);
                    check("dut1 tries",     64'(b1.tries),     64'(e.tries));
                    check("dut1 runs",      64'(runs1),        64'(e.runs));
                end
            end
        end
    end

    task automatic issue(int d, logic [31:0] seed, logic [31:0] acc);
        exp_t e;
        @(negedge clk);
        if (d == 0) begin
            e = model(64'(seed), 1024);
            e.runs += runs0;
            cur_acc0 = acc;
            b0.seed_number = seed; b0.accuracy = acc; b0.start = 1'b1;
            q0.push_back(e);
        end else begin
            e = model(64'(seed), 2);
            e.runs += runs1;
            cur_acc1 = acc;
            b1.seed_number = seed; b1.accuracy = acc; b1.start = 1'b1;
            q1.push_back(e);
        end
        @(negedge clk);
        b0.start = 1'b0;
        b1.start = 1'b0;
    endtask

    task automatic wait_done(int d);
        for (int i = 0; i < 20000; i++) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) return;
            @(negedge clk);
        end
        fail_evt(d == 0 ? "dut0 done timeout" : "dut1 done timeout");
        q0.delete();
        q1.delete();
    endtask

    task automatic wait_wait_state(string name);
        for (int i = 0; i < 50; i++) begin
            if (!b0.mr_reset) return;
            @(negedge clk);
        end
        fail_evt(name);
    endtask

    task automatic check_reset_values(string tag);
        check({tag, " busy"},            64'(b0.busy),            64'(0));
        check({tag, " done"},            64'(b0.done),            64'(0));
        check({tag, " found"},           64'(b0.found),           64'(0));
        check({tag, " overflow"},        64'(b0.overflow),        64'(0));
        check({tag, " prime_out"},       64'(b0.prime_out),       64'(0));
        check({tag, " tries"},           64'(b0.tries),           64'(0));
        check({tag, " mr_reset"},        64'(b0.mr_reset),        64'(1));
        check({tag, " mr_start_number"}, 64'(b0.mr_start_number), 64'(0));
        check({tag, " mr_accuracy"},     64'(b0.mr_accuracy),     64'(0));
    endtask

    initial begin
        logic [31:0] s;
        rst = 1'b1;
        b0.start = 0; b0.abort = 0; b0.seed_number = 0; b0.accuracy = 0;
        b1.start = 0; b1.abort = 0; b1.seed_number = 0; b1.accuracy = 0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Directed searches
        issue(0, 32'd14, 32'd8);          wait_done(0);
        issue(0, 32'd24, 32'd8);          wait_done(0);
        issue(0, 32'd2, 32'd5);
        check("seed2 mr_reset c1", 64'(b0.mr_reset), 64'(1));
        @(negedge clk);
        check("seed2 done at c2", 64'(b0.done), 64'(1));
        check("seed2 mr_reset c2", 64'(b0.mr_reset), 64'(1));
        wait_done(0);
        issue(0, 32'd3, 32'd5);           wait_done(0);
        issue(0, 32'd0, 32'd1);           wait_done(0);
        issue(0, 32'd1, 32'd1);           wait_done(0);
        issue(0, 32'hFFFF_FFFF, 32'd8);   wait_done(0);
        issue(1, 32'd24, 32'd8);          wait_done(1);

        // Abort during WAIT: no done, results held
        @(negedge clk);
        cur_acc0 = 32'd8;
        b0.seed_number = 32'd24; b0.accuracy = 32'd8; b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        wait_wait_state("abort reach WAIT");
        b0.abort = 1'b1;
        @(negedge clk);
        b0.abort = 1'b0;
        check("abort busy",      64'(b0.busy),      64'(0));
        check("abort mr_reset",  64'(b0.mr_reset),  64'(1));
        check("abort done",      64'(b0.done),      64'(0));
        if (!SIEVE) begin
            check("abort prime_out", 64'(b0.prime_out), 64'd25);
            check("abort tries",     64'(b0.tries),     64'd1);
        end
        repeat (6) @(negedge clk);

        // start together with abort in IDLE is dropped
        b0.seed_number = 32'd50; b0.start = 1'b1; b0.abort = 1'b1;
        @(negedge clk);
        b0.start = 1'b0; b0.abort = 1'b0;
        check("start+abort busy", 64'(b0.busy), 64'(0));
        repeat (4) @(negedge clk);
        check("start+abort mr_reset", 64'(b0.mr_reset), 64'(1));

        issue(0, 32'd14, 32'd3);          wait_done(0);

        // Asynchronous reset mid-WAIT
        @(negedge clk);
        cur_acc0 = 32'd4;
        b0.seed_number = 32'd14; b0.accuracy = 32'd4; b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        wait_wait_state("reset reach WAIT");
        #2 rst = 1'b1;
        #1 check_reset_values("async reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized searches
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 2))
                0:       s = $urandom_range(0, 300);
                1:       s = 32'hFFFF_FFFF - $urandom_range(0, 60);
                default: s = $urandom;
            endcase
            issue(0, s, $urandom_range(1, 64));
            wait_done(0);
        end
        for (int i = 0; i < 6; i++) begin
            s = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 400) : $urandom;
            issue(1, s, $urandom_range(1, 64));
            wait_done(1);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/prime_search_ctrl.md
Name: prime_search_ctrl

Overview:
Sequencing controller for the miller_rabin tester. It takes a seed and walks odd candidates upward from it. For each candidate it loads and resets the tester, waits for the tester's finish, and evaluates the verdict. It stops on the first probable prime, on a try limit, on word overflow, or on abort. It sits between the top-level prime generator request interface and one miller_rabin instance that it owns exclusively.

Parameters:
WORDSIZE, 32, candidate/accuracy width; must match the tester instance
MAX_TRIES, 1024, maximum candidates examined per search (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
start  input  1  one-cycle request pulse; sampled only in IDLE
abort  input  1  cancel the current search; returns to IDLE
seed_number  input  WORDSIZE  search start value, latched on start
accuracy  input  WORDSIZE  Miller-Rabin rounds, latched on start
busy  output  1  high from the cycle after accepted start until done/abort
done  output  1  one-cycle pulse when the search ends (not on abort)
found  output  1  valid with done: 1 = prime_out is a probable prime
overflow  output  1  valid with done: 1 = the candidate would wrap past 2^WORDSIZE-1
prime_out  output  WORDSIZE  last candidate examined; held until next start
tries  output  16  candidates examined in this search; held until next start
mr_start_number  output  WORDSIZE  tester start_number
mr_accuracy  output  WORDSIZE  tester accuracy
mr_reset  output  1  tester reset (registered)
mr_prime  input  1  tester prime
mr_finish  input  1  tester finish

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - busy, done, found, overflow = 0; prime_out, tries = 0.
  - mr_reset=1, holding the tester idle; mr_start_number, mr_accuracy = 0.
- All outputs are registered.
- States and transitions:
  - IDLE: mr_reset=1.
    - start (abort low) with seed<=2: prime_out=2, go to FINISH with found=1, tries=0.
    - start with seed==3: prime_out=3, go to FINISH with found=1, tries=0.
    - Otherwise: candidate = seed|1, latch accuracy, tries=0, go to ISSUE.
  - ISSUE (1 cycle): drive mr_start_number=candidate, mr_accuracy=latched accuracy, mr_reset=1; tries+=1. Go to GUARD.
  - GUARD (1 cycle): mr_reset=0; mr_finish ignored because it is stale from the previous HOLD. Go to WAIT.
  - WAIT: mr_reset=0; on mr_finish=1, capture mr_prime and go to EVAL. No per-test timeout (unless the optional feature is enabled).
  - EVAL (1 cycle), checked in this order:
    - mr_prime=1: found=1, go to FINISH.
    - tries==MAX_TRIES: found=0, go to FINISH.
    - candidate > 2^WORDSIZE-3: overflow=1, found=0, go to FINISH.
    - Otherwise: candidate+=2, go to ISSUE.
  - FINISH (1 cycle): done=1, busy=0, mr_reset=1. Go to IDLE.
- prime_out tracks candidate from ISSUE onward.
- abort in any non-IDLE state: next state IDLE, busy=0, mr_reset=1, no done pulse; prime_out and tries keep their current values.
- start while busy is ignored. start and abort together in IDLE: abort wins, request dropped.
- Latency per tested candidate: 3 cycles plus tester run time.
- Arithmetic:
  - candidate is unsigned WORDSIZE; the +2 step must never wrap (guarded by the overflow check).
  - tries saturates at 16'hFFFF.
  - MAX_TRIES > 65535 is unsupported.

Optional Feature:
PRIME_SEARCH_SIEVE_EN
- When defined, the controller keeps residues of candidate mod 3, 5 and 7:
  - Residues are computed once on the IDLE→ISSUE transition.
  - They are updated by +2 with modular wrap on each step; no divider in the loop.
- In a SIEVE state entered in place of ISSUE: if any residue==0 and candidate>7, then tries+=1 and the candidate is rejected without invoking the tester. The rejected candidate goes through the same EVAL limit/overflow checks, with mr_prime treated as 0.
- When undefined: no residue registers; every candidate goes to the tester.

Test Plan:
- seed=14, accuracy=8 → tester runs on 15 (composite) then 17; done with found=1, prime_out=17, tries=2, overflow=0. With SIEVE_EN: 15 is sieved; tries=2, tester invoked once.
- seed=24, accuracy=8 → 25 and 27 rejected, then done with found=1, prime_out=29, tries=3. With SIEVE_EN: mr_reset toggles for 29 only.
- seed=2 → done 2 cycles after start with found=1, prime_out=2, tries=0, and mr_reset held high throughout. seed=3 → prime_out=3.
- seed=32'hFFFFFFFF (composite) → single tester run, then done with found=0, overflow=1, prime_out=32'hFFFFFFFF, tries=1.
- MAX_TRIES=2, seed=24 → done with found=0, overflow=0, tries=2, prime_out=27.
- abort in WAIT during seed=24 → busy falls next cycle with no done pulse, mr_reset=1. Then start with seed=14 → found=1, prime_out=17. Async reset asserted mid-WAIT → all outputs at reset values immediately.
